// File: rtl/circuit1_sequencer.sv
// circuit1_sequencer
//   Exhaustive tester for the 3-input combinational circuit f = (a&b)|~c.
//   A run walks the vector {a,b,c} through 0..7. Each vector is held for
//   SETTLE+1 cycles, and f_in is captured on the last cycle of that hold.
//   The captured truth table is then compared against the golden EXPECTED
//   table.
//
// Parameters
//   SETTLE    cycles each vector is held before f_in is sampled (0..15)
//   EXPECTED  golden truth table, bit i = expected f for {a,b,c}=i
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        run request, honoured only while idle
//   abort        terminate the current run (only effective while driving)
//   f_in         output of the circuit under test
//   a, b, c      registered stimulus to the circuit under test ({a,b,c}=vec)
//   busy         high while a run is in progress (DRIVE or DONE)
//   done         one-cycle pulse on normal completion
//   truth_table  captured f per vector
//   fail_mask    truth_table ^ EXPECTED, valid from the done pulse onward
//   err_count    population count of fail_mask
//   pass         last run completed with no mismatching vectors
//   aborted      last run was terminated by abort
module circuit1_sequencer #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [7:0]  EXPECTED = 8'hD5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic [7:0] fail_mask,
    output logic [3:0] err_count,
    output logic       pass,
    output logic       aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state_r;
    logic [2:0] vec_r;
    logic [3:0] cnt_r;

    logic [7:0] tt_next_s;
    logic [7:0] fail_next_s;
    logic [3:0] err_next_s;

    // Number of set bits in an 8-bit word (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // The stimulus pins are the vector register itself, so a, b and c are
    // flop outputs and {a,b,c} equals vec at all times.
    assign {a, b, c} = vec_r;

    // Truth table including the bit being captured this cycle, so the final
    // comparison sees the complete table on the DRIVE-to-DONE edge.
    always_comb begin
        tt_next_s        = truth_table;
        tt_next_s[vec_r] = f_in;
        fail_next_s      = tt_next_s ^ EXPECTED;
        err_next_s       = popcount8(fail_next_s);
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            vec_r       <= 3'd0;
            cnt_r       <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 8'h00;
            fail_mask   <= 8'h00;
            err_count   <= 4'd0;
            pass        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    // start wins over a simultaneous abort here.
                    if (start) begin
                        state_r     <= DRIVE;
                        vec_r       <= 3'd0;
                        cnt_r       <= 4'd0;
                        busy        <= 1'b1;
                        truth_table <= 8'h00;
                        err_count   <= 4'd0;
                        pass        <= 1'b0;
                        aborted     <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        // Already-captured truth table bits are kept.
                        state_r <= IDLE;
                        vec_r   <= 3'd0;
                        cnt_r   <= 4'd0;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        pass    <= 1'b0;
                    end else if (cnt_r != SETTLE_CNT) begin
                        cnt_r <= cnt_r + 4'd1;
                    end else begin
                        truth_table <= tt_next_s;
                        cnt_r       <= 4'd0;
                        if (vec_r != 3'd7) begin
                            vec_r <= vec_r + 3'd1;
                        end else begin
                            state_r   <= DONE;
                            done      <= 1'b1;
                            fail_mask <= fail_next_s;
                            err_count <= err_next_s;
                            pass      <= (err_next_s == 4'd0);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circuit1_sequencer.sv
// Directed testbench for circuit1_sequencer. dut drives a golden or
// stuck-at-0 model of f = (a&b)|~c with SETTLE=2; dut2 uses SETTLE=0 for
// the back-to-back runs.
module tb_circuit1_sequencer;

    logic       clk;
    logic       reset;
    logic       start, abort;
    logic       f_in;
    logic       a, b, c, busy, done, pass, aborted;
    logic [7:0] truth_table, fail_mask;
    logic [3:0] err_count;
    logic       mode_stuck;

    logic       start2, f_in2;
    logic       a2, b2, c2, busy2, done2, pass2, aborted2;
    logic [7:0] tt2, fm2;
    logic [3:0] ec2;

    int n_checks;
    int n_pass;

    // Circuit under test: golden function, or output stuck at 0.
    assign f_in  = mode_stuck ? 1'b0 : ((a & b) | ~c);
    assign f_in2 = (a2 & b2) | ~c2;

    circuit1_sequencer #(.SETTLE(2), .EXPECTED(8'hD5)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .f_in(f_in),
        .a(a), .b(b), .c(c), .busy(busy), .done(done),
        .truth_table(truth_table), .fail_mask(fail_mask),
        .err_count(err_count), .pass(pass), .aborted(aborted)
    );

    circuit1_sequencer #(.SETTLE(0), .EXPECTED(8'hD5)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .f_in(f_in2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2),
        .truth_table(tt2), .fail_mask(fm2),
        .err_count(ec2), .pass(pass2), .aborted(aborted2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Starts a run and follows it until busy drops (bounded). Counts the
    // busy cycles, the busy cycle holding done, and the done pulses.
    // Optionally pulses start mid-run and asserts abort during DONE.
    task automatic do_run(input bit with_abort, input int pulse_at,
                          input bit abort_in_done, output int busy_cycles,
                          output int done_cycle, output int done_pulses);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        busy_cycles = 0;
        done_cycle  = 0;
        done_pulses = 0;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            if (done === 1'b1) begin
                done_pulses++;
                done_cycle = busy_cycles;
            end
            start = (busy_cycles == pulse_at);
            abort = abort_in_done && (done === 1'b1);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({a, b, c, busy, done, truth_table, fail_mask, err_count, pass, aborted} !== 27'd0) $display("FAIL reset_state: got %h want 0", {a, b, c, busy, done, truth_table, fail_mask, err_count, pass, aborted}); else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if ({busy, a, b, c} !== 4'b1000) $display("FAIL reset_first_start: busy,abc got %b want 1000", {busy, a, b, c}); else n_pass++;
        repeat (4) @(negedge clk);
        // Assert reset between clock edges; outputs must clear before any edge.
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({busy, a, b, c, truth_table} !== 12'd0) $display("FAIL reset_async: busy,abc,tt got %h want 0", {busy, a, b, c, truth_table}); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_golden();
        int bc, dc, dp;
        mode_stuck = 1'b0;
        do_run(1'b0, 5, 1'b0, bc, dc, dp);
        // 8 vectors * 3 cycles in DRIVE + 1 DONE cycle = 25 busy cycles.
        n_checks++; if (bc !== 25) $display("FAIL golden_busy_cycles: got %0d want 25", bc); else n_pass++;
        n_checks++; if (dc !== 25 || dp !== 1) $display("FAIL golden_done: cycle %0d pulses %0d want 25/1", dc, dp); else n_pass++;
        n_checks++; if (truth_table !== 8'hD5) $display("FAIL golden_tt: got %h want d5", truth_table); else n_pass++;
        n_checks++; if (fail_mask !== 8'h00) $display("FAIL golden_fail_mask: got %h want 00", fail_mask); else n_pass++;
        n_checks++; if (err_count !== 4'd0) $display("FAIL golden_err_count: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (pass !== 1'b1 || aborted !== 1'b0) $display("FAIL golden_pass: pass %b aborted %b want 1/0", pass, aborted); else n_pass++;
    endtask

    task automatic test_stuck();
        int bc, dc, dp;
        mode_stuck = 1'b1;
        do_run(1'b0, 0, 1'b1, bc, dc, dp);
        mode_stuck = 1'b0;
        n_checks++; if (bc !== 25 || dp !== 1) $display("FAIL stuck_run: busy %0d pulses %0d want 25/1", bc, dp); else n_pass++;
        n_checks++; if (truth_table !== 8'h00) $display("FAIL stuck_tt: got %h want 00", truth_table); else n_pass++;
        n_checks++; if (fail_mask !== 8'hD5) $display("FAIL stuck_fail_mask: got %h want d5", fail_mask); else n_pass++;
        n_checks++; if (err_count !== 4'd5) $display("FAIL stuck_err_count: got %0d want 5", err_count); else n_pass++;
        // abort was asserted during DONE and must have been ignored.
        n_checks++; if (pass !== 1'b0 || aborted !== 1'b0) $display("FAIL stuck_pass: pass %b aborted %b want 0/0", pass, aborted); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int i, bc, dc, dp;
        mode_stuck = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while ({a, b, c} !== 3'd5 && i < 100) begin
            @(negedge clk);
            i++;
        end
        n_checks++; if (i >= 100) $display("FAIL midrun_reach_vec5: got timeout want vec=5"); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({a, b, c, busy, done, truth_table, fail_mask, err_count, pass, aborted} !== 27'd0) $display("FAIL midrun_reset_clear: got %h want 0", {a, b, c, busy, done, truth_table, fail_mask, err_count, pass, aborted}); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL midrun_no_done: busy,done got %b want 00", {busy, done}); else n_pass++;
        do_run(1'b0, 0, 1'b0, bc, dc, dp);
        n_checks++; if (bc !== 25 || dc !== 25 || truth_table !== 8'hD5 || pass !== 1'b1) $display("FAIL midrun_fresh_run: busy %0d done@%0d tt %h pass %b want 25/25/d5/1", bc, dc, truth_table, pass); else n_pass++;
    endtask

    task automatic test_abort();
        int i;
        bit saw_done;
        mode_stuck = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while ({a, b, c} !== 3'd3 && i < 100) begin
            @(negedge clk);
            i++;
        end
        n_checks++; if (i >= 100) $display("FAIL abort_reach_vec3: got timeout want vec=3"); else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || {a, b, c} !== 3'd0) $display("FAIL abort_idle: busy %b abc %b want 0/000", busy, {a, b, c}); else n_pass++;
        n_checks++; if (aborted !== 1'b1 || pass !== 1'b0) $display("FAIL abort_flags: aborted %b pass %b want 1/0", aborted, pass); else n_pass++;
        // Vectors 0..2 captured as 1,0,1; the rest were cleared on start.
        n_checks++; if (truth_table !== 8'h05) $display("FAIL abort_tt: got %h want 05", truth_table); else n_pass++;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got activity want none"); else n_pass++;
    endtask

    task automatic test_idle_abort();
        int bc, dc, dp;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || aborted !== 1'b1 || truth_table !== 8'h05) $display("FAIL idle_abort_ignored: busy %b aborted %b tt %h want 0/1/05", busy, aborted, truth_table); else n_pass++;
        // start and abort together in IDLE behave as a plain start.
        do_run(1'b1, 0, 1'b0, bc, dc, dp);
        n_checks++; if (bc !== 25 || dp !== 1) $display("FAIL start_abort_run: busy %0d pulses %0d want 25/1", bc, dp); else n_pass++;
        n_checks++; if (aborted !== 1'b0 || pass !== 1'b1 || truth_table !== 8'hD5) $display("FAIL start_abort_result: aborted %b pass %b tt %h want 0/1/d5", aborted, pass, truth_table); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit bh[60];
        bit dh[60];
        int win_len, wins, bad_len, gaps_bad, gap, dones, done_bad;
        bit seen_win;
        start2 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bh[i] = busy2;
            dh[i] = done2;
        end
        start2 = 1'b0;
        win_len = 0; wins = 0; bad_len = 0; gaps_bad = 0; gap = 0;
        dones = 0; done_bad = 0; seen_win = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bh[i]) begin
                if (win_len == 0 && seen_win && gap != 1) gaps_bad++;
                win_len++;
                gap = 0;
                if (dh[i]) dones++;
            end else begin
                if (win_len > 0) begin
                    wins++;
                    if (win_len != 9) bad_len++;
                    if (!dh[i-1]) done_bad++;
                    seen_win = 1'b1;
                end
                win_len = 0;
                gap++;
            end
        end
        n_checks++; if (wins < 2) $display("FAIL b2b_runs: got %0d completed runs want >=2", wins); else n_pass++;
        n_checks++; if (bad_len !== 0) $display("FAIL b2b_window_len: got %0d windows not 9 cycles want 0", bad_len); else n_pass++;
        n_checks++; if (gaps_bad !== 0) $display("FAIL b2b_gap: got %0d gaps not 1 cycle want 0", gaps_bad); else n_pass++;
        n_checks++; if (dones !== wins || done_bad !== 0) $display("FAIL b2b_done: pulses %0d misplaced %0d want %0d/0", dones, done_bad, wins); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (busy2 !== 1'b0 || tt2 !== 8'hD5 || pass2 !== 1'b1 || ec2 !== 4'd0) $display("FAIL b2b_result: busy %b tt %h pass %b err %0d want 0/d5/1/0", busy2, tt2, pass2, ec2); else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start2     = 1'b0;
        mode_stuck = 1'b0;
        test_reset();
        test_golden();
        test_stuck();
        test_reset_midrun();
        test_abort();
        test_idle_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
